rom_download_ctrl: RTL

ROM_DOWNLOAD_CTRL -- requirements
Module: rom_download_ctrl

---
 rtl/rom_download_ctrl.sv | 132 +++++++++++++
 1 files changed

// File: rtl/rom_download_ctrl.sv
// Converts host download strobes into toggle-handshake 16-bit ROM writes, tracks size/header offset,
// and seeds backup RAM after reset or download start. One word in flight; dl_wait holds off the host.
module rom_download_ctrl #(
  parameter int ADDR_W   = 24,
  parameter int HDR_SIZE = 512
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              dl_active,
  input  logic              dl_wr,
  input  logic [15:0]       dl_data,
  input  logic              swap_en,
  output logic              dl_wait,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_din,
  output logic              mem_req,
  input  logic              mem_ack,
  output logic [7:0]        rom_sz,
  output logic [ADDR_W-1:0] rd_offset,
  output logic              rom_valid,
  output logic              overflow,
  output logic [2:0]        bram_init_addr,
  output logic [15:0]       bram_init_data,
  output logic              bram_init_we
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ACK} state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR    = {{(ADDR_W-1){1'b1}}, 1'b0};
  localparam logic [63:0]       HDR_MOD_MASK = 64'(HDR_SIZE) * 64'd16 - 64'd1;

  state_t            state, state_nxt;
  logic              dl_active_d;
  logic              fin_pend;
  logic [ADDR_W-1:0] count;
  logic [63:0]       count_wide;
  logic [3:0]        init_cnt;
  logic              dl_rise, dl_fall, ack_match, accept, issue_go, ack_done, finalize;

  function automatic logic [7:0] rev8(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = b[7-i];
    return r;
  endfunction

  assign count_wide = 64'(count);

  always_comb begin
    dl_rise   = dl_active & ~dl_active_d;
    dl_fall   = ~dl_active & dl_active_d;
    ack_match = (mem_ack == mem_req);
    accept    = (state == IDLE) & dl_wr & dl_active & ~dl_rise;
    // ISSUE also waits for a matched ack so a stale request can never be toggled twice
    issue_go  = (state == ISSUE) & ack_match;
    ack_done  = (state == WAIT_ACK) & ack_match;
    finalize  = (fin_pend | dl_fall) & ~dl_active & (state == IDLE);
    state_nxt = state;
    case (state)
      IDLE:     if (accept) state_nxt = overflow ? WAIT_ACK : ISSUE;
      ISSUE:    if (issue_go) state_nxt = WAIT_ACK;
      WAIT_ACK: if (ack_match) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
    if (dl_rise) state_nxt = IDLE;
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state       <= IDLE;
      dl_active_d <= 1'b0;
      fin_pend    <= 1'b0;
      count       <= '0;
      init_cnt    <= '0;
      dl_wait     <= 1'b0;
      mem_req     <= 1'b0;
      mem_addr    <= '0;
      mem_din     <= '0;
      rom_sz      <= '0;
      rd_offset   <= '0;
      rom_valid   <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      state       <= state_nxt;
      dl_active_d <= dl_active;
      if (dl_rise) begin
        count     <= '0;
        overflow  <= 1'b0;
        rom_valid <= 1'b0;
        init_cnt  <= '0;
        fin_pend  <= 1'b0;
        dl_wait   <= 1'b0;
      end else begin
        if (init_cnt != 4'd8) init_cnt <= init_cnt + 4'd1;
        if (accept) begin
          mem_din <= swap_en ? {rev8(dl_data[15:8]), rev8(dl_data[7:0])} : dl_data;
          dl_wait <= 1'b1;
          if (!overflow && count == LAST_ADDR) overflow <= 1'b1;
        end
        if (issue_go) begin
          mem_addr <= count;
          mem_req  <= ~mem_req;
        end
        // the word at the top address is written but leaves count parked there
        if (ack_done) begin
          dl_wait <= 1'b0;
          if (!overflow) count <= count + ADDR_W'(2);
        end
        if (finalize) begin
          rom_sz    <= count_wide[23:16];
          rd_offset <= ((count_wide & HDR_MOD_MASK) == 64'(HDR_SIZE)) ? ADDR_W'(HDR_SIZE) : '0;
          rom_valid <= 1'b1;
          fin_pend  <= 1'b0;
        end else if (dl_fall) begin
          fin_pend  <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    bram_init_addr = init_cnt[3:1];
    bram_init_we   = init_cnt[0] & ~init_cnt[3];
    case (init_cnt[3:1])
      3'd0:    bram_init_data = 16'h4855;
      3'd1:    bram_init_data = 16'h424D;
      3'd2:    bram_init_data = 16'h0088;
      3'd3:    bram_init_data = 16'h1080;
      default: bram_init_data = 16'h0000;
    endcase
  end

endmodule
